// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: CPU data port plus EXRAM port, bundled for the bridge.
//   cpu_addr/cpu_wdata/cpu_we/cpu_re : CPU request side
//   cpu_rdata                        : read data, one cycle after the address
//   ram_addr/ram_wdata/ram_we        : forwarded to EXRAM
//   ram_q                            : EXRAM registered read data
// master = CPU + EXRAM side, slave = the bridge.
interface mem_io_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, ram_q,
    input  cpu_rdata, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, ram_q,
    output cpu_rdata, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: memory-mapped I/O bridge between the CPU data port and EXRAM.
// Addresses >= IO_BASE hit a small register file; everything below is RAM.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mem_io_bridge_if.slave (CPU + EXRAM signals)
//   switches   : asynchronous board switches (synchronized here)
//   seg        : active-low 7-seg segments, digit i at [7i+6:7i], bit0=a
//   sw_event   : sticky switch-change flag (SW_EVENT bit0)
// Register offsets from IO_BASE:
//   0 SWITCHES (RO)  1 DISPLAY (RW)  2 BLANK (RW)  3 SW_EVENT (RO, clear-on-read)
//   4 TICK (RW)      others read 0, writes dropped.

// One digit: hex decode, blanking, registered output.
module seg7_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] dec;

  // Active-low, bit order g..a.
  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg <= 7'h7F;
    else       seg <= blank ? 7'h7F : dec;
  end
endmodule

module mem_io_bridge #(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] IO_BASE   = 16'hCFFD,
  parameter int              NUM_DIGITS  = 4,
  parameter int              SW_W        = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              PRESCALE    = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_io_bridge_if.slave          bus,
  input  logic [SW_W-1:0]         switches,
  output logic [NUM_DIGITS*7-1:0] seg,
  output logic                    sw_event
);
  localparam int DISP_W = NUM_DIGITS * 4;
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // ---------------------------------------------------------------- decode
  logic              in_io;
  logic [ADDR_W-1:0] off;
  logic              sel_sw, sel_disp, sel_blank, sel_evt, sel_tick;

  assign in_io     = bus.cpu_addr >= IO_BASE;
  assign off       = bus.cpu_addr - IO_BASE;
  assign sel_sw    = in_io && (off == ADDR_W'(0));
  assign sel_disp  = in_io && (off == ADDR_W'(1));
  assign sel_blank = in_io && (off == ADDR_W'(2));
  assign sel_evt   = in_io && (off == ADDR_W'(3));
  assign sel_tick  = in_io && (off == ADDR_W'(4));

  // RAM sees every address, but never a write inside the I/O window.
  assign bus.ram_addr  = bus.cpu_addr;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.ram_we    = bus.cpu_we & ~in_io;

  // ---------------------------------------------------------- synchronizer
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_pipe;
  logic [SW_W-1:0]                  sw_sync, sw_sync_prev;

  assign sw_sync = sw_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_pipe      <= '0;
      sw_sync_prev <= '0;
    end else begin
      sw_pipe      <= {sw_pipe[SYNC_STAGES-2:0], switches};
      sw_sync_prev <= sw_sync;
    end
  end

  // -------------------------------------------------------------- SW_EVENT
  // A change seen on the same edge as a clearing read keeps the flag set,
  // so no event can be lost between the read and the clear.
  logic sw_chg, evt_clr, sw_evt;

  assign sw_chg  = sw_sync != sw_sync_prev;
  assign evt_clr = sel_evt & bus.cpu_re;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sw_evt <= 1'b0;
    else if (sw_chg)  sw_evt <= 1'b1;
    else if (evt_clr) sw_evt <= 1'b0;
  end

  assign sw_event = sw_evt;

  // ------------------------------------------------------------------ TICK
  // A CPU write restarts the prescale period so the loaded value lasts a
  // full PRESCALE cycles before the first increment.
  logic [PS_W-1:0]   presc;
  logic [DATA_W-1:0] tick;
  logic              presc_wrap;

  assign presc_wrap = presc == PS_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tick  <= '0;
    end else if (sel_tick && bus.cpu_we) begin
      presc <= '0;
      tick  <= bus.cpu_wdata;
    end else if (presc_wrap) begin
      presc <= '0;
      tick  <= tick + DATA_W'(1);
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // -------------------------------------------------------- DISPLAY / BLANK
  logic [DISP_W-1:0]     disp;
  logic [NUM_DIGITS-1:0] blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp  <= '0;
      blank <= '1;            // display dark out of reset
    end else begin
      if (sel_disp && bus.cpu_we)  disp  <= bus.cpu_wdata[DISP_W-1:0];
      if (sel_blank && bus.cpu_we) blank <= bus.cpu_wdata[NUM_DIGITS-1:0];
    end
  end

  // ------------------------------------------------------------- read path
  // I/O data is registered so it lines up with EXRAM's registered ram_q.
  logic [DATA_W-1:0] rd_val, io_rdata_q;
  logic              io_sel_q;

  always_comb begin
    rd_val = '0;
    if (sel_sw)    rd_val = DATA_W'(sw_sync);
    if (sel_disp)  rd_val = DATA_W'(disp);
    if (sel_blank) rd_val = DATA_W'(blank);
    if (sel_evt)   rd_val = DATA_W'(sw_evt);
    if (sel_tick)  rd_val = tick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= in_io;
      io_rdata_q <= rd_val;
    end
  end

  assign bus.cpu_rdata = io_sel_q ? io_rdata_q : bus.ram_q;

  // ---------------------------------------------------------------- digits
  logic [NUM_DIGITS-1:0][3:0] nib;
  assign nib = disp;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg7_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .nib   (nib[i]),
      .blank (blank[i]),
      .seg   (seg[7*i +: 7])
    );
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;
  localparam int          ND   = 4;
  localparam int          SYNC = 2;
  localparam int          PS   = 4;
  localparam logic [15:0] IO_BASE = 16'hCFFD;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switches;
  logic [27:0] seg;
  logic        sw_event;

  int n_checks = 0;
  int n_errors = 0;

  mem_io_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_io_bridge #(
    .DATA_W(16), .ADDR_W(16), .IO_BASE(IO_BASE), .NUM_DIGITS(ND),
    .SW_W(8), .SYNC_STAGES(SYNC), .PRESCALE(PS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .seg      (seg),
    .sw_event (sw_event)
  );

  always #5 clk = ~clk;

  // EXRAM: registered read, old data on a same-cycle write.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Hex font, active-low, g..a.
  function automatic logic [6:0] font(input int n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n & 15];
  endfunction

  function automatic logic [27:0] segs(input int unsigned d, input int unsigned b);
    logic [27:0] s;
    s = '1;
    for (int i = 0; i < ND; i++)
      if (((b >> i) & 1) == 0) s[7*i +: 7] = font(int'((d >> (4*i)) & 15));
    return s;
  endfunction

  // ---------------------------------------------------------------- model
  // Register contents as plain integers; the switch path is a history of
  // raw samples (sync = sampled SYNC edges ago, prev = one edge older).
  int unsigned m_disp, m_blank, m_evt, m_tick, m_presc, m_rdata;
  bit          m_sel;
  logic [27:0] m_seg;
  logic [7:0]  m_hist [0:SYNC];

  always @(posedge clk or posedge reset) begin : mdl
    bit io;
    int off;
    int unsigned rv;
    if (reset) begin
      m_disp = 0; m_blank = (1 << ND) - 1; m_evt = 0; m_tick = 0; m_presc = 0;
      m_sel = 0; m_rdata = 0; m_seg = '1;
      for (int i = 0; i <= SYNC; i++) m_hist[i] = 8'h00;
    end else begin
      io  = bus.cpu_addr >= IO_BASE;
      off = int'(bus.cpu_addr) - int'(IO_BASE);
      rv  = 0;
      if (io) begin
        case (off)
          0: rv = m_hist[SYNC-1];
          1: rv = m_disp;
          2: rv = m_blank;
          3: rv = m_evt;
          4: rv = m_tick;
          default: rv = 0;
        endcase
      end
      m_sel   = io;
      m_rdata = rv;
      m_seg   = segs(m_disp, m_blank);
      if (m_hist[SYNC-1] != m_hist[SYNC]) m_evt = 1;
      else if (io && bus.cpu_re && off == 3) m_evt = 0;
      for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = switches;
      if (io && bus.cpu_we && off == 4) begin
        m_tick = bus.cpu_wdata; m_presc = 0;
      end else begin
        m_presc++;
        if (m_presc == PS) begin m_presc = 0; m_tick = (m_tick + 1) & 32'hFFFF; end
      end
      if (io && bus.cpu_we && off == 1) m_disp  = bus.cpu_wdata;
      if (io && bus.cpu_we && off == 2) m_blank = bus.cpu_wdata & ((1 << ND) - 1);
    end
  end

  // Every cycle, mid-period, compare all outputs with the model.
  always @(negedge clk) begin
    chk("seg", seg, m_seg);
    chk("sw_event", sw_event, m_evt);
    chk("cpu_rdata", bus.cpu_rdata, m_sel ? m_rdata : bus.ram_q);
    chk("ram_we", bus.ram_we, bus.cpu_we && (bus.cpu_addr < IO_BASE));
    chk("ram_addr", bus.ram_addr, bus.cpu_addr);
    chk("ram_wdata", bus.ram_wdata, bus.cpu_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we, input logic re);
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_we = we; bus.cpu_re = re;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 3 + 7);
    reset = 1'b1; switches = 8'h00;
    drive(16'h0000, 16'h0000, 0, 0);
    repeat (2) step();
    reset = 1'b0;
    chk("reset_seg", seg, 28'hFFFFFFF);
    chk("reset_sw_event", sw_event, 0);

    // Reset mid-write to DISPLAY
    switches = 8'h3C;
    repeat (4) step();
    chk("pre_reset_event", sw_event, 1);
    drive(IO_BASE + 16'd1, 16'h5678, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_seg", seg, 28'hFFFFFFF);
    chk("midreset_sw_event", sw_event, 0);
    drive(16'h0000, 16'h0000, 0, 0);
    step();
    reset = 1'b0;
    drive(IO_BASE + 16'd4, 16'h0000, 0, 0);
    step();
    chk("tick_after_reset", bus.cpu_rdata, 16'h0000);
    drive(IO_BASE + 16'd1, 16'h0000, 0, 0);
    step();
    chk("display_after_reset", bus.cpu_rdata, 16'h0000);

    // DISPLAY / BLANK
    drive(IO_BASE + 16'd1, 16'h1234, 1, 0); step();
    drive(IO_BASE + 16'd2, 16'h0000, 1, 0); step();
    drive(16'h0000, 16'h0000, 0, 0);        step();
    chk("seg_1234", seg, {7'h79, 7'h24, 7'h30, 7'h19});
    chk("model_seg_1234", m_seg, {7'h79, 7'h24, 7'h30, 7'h19});
    drive(IO_BASE + 16'd1, 16'h0000, 0, 0); step();
    chk("read_display", bus.cpu_rdata, 16'h1234);

    // Switches and SW_EVENT
    switches = 8'hA5;
    drive(16'h0000, 16'h0000, 0, 0);
    repeat (3) step();
    chk("sw_event_set", sw_event, 1);
    drive(IO_BASE, 16'h0000, 0, 0); step();
    chk("read_switches", bus.cpu_rdata, 16'h00A5);
    drive(IO_BASE + 16'd3, 16'h0000, 0, 1); step();
    chk("read_event", bus.cpu_rdata, 16'h0001);
    chk("event_cleared", sw_event, 0);
    switches = 8'h5A;
    drive(16'h0000, 16'h0000, 0, 0);
    repeat (2) step();
    drive(IO_BASE + 16'd3, 16'h0000, 0, 1); step();
    chk("collide_read", bus.cpu_rdata, 16'h0000);
    chk("collide_set_wins", sw_event, 1);
    step();
    chk("collide_reread", bus.cpu_rdata, 16'h0001);
    chk("collide_cleared", sw_event, 0);

    // RAM vs unmapped I/O, address boundaries
    drive(16'h0100, 16'h00FF, 1, 0); #1;
    chk("ram_we_ram", bus.ram_we, 1);
    step();
    drive(IO_BASE + 16'd7, 16'hBEEF, 1, 0); #1;
    chk("ram_we_io", bus.ram_we, 0);
    step();
    drive(IO_BASE - 16'd1, 16'h1357, 1, 0); #1;
    chk("ram_we_base_m1", bus.ram_we, 1);
    step();
    drive(16'hFFFF, 16'h2468, 1, 0); #1;
    chk("ram_we_top", bus.ram_we, 0);
    step();
    drive(16'h0100, 16'h0000, 0, 0); step();
    chk("read_ram_0100", bus.cpu_rdata, 16'h00FF);
    drive(IO_BASE + 16'd7, 16'h0000, 0, 0); step();
    chk("read_unmapped", bus.cpu_rdata, 16'h0000);
    drive(IO_BASE - 16'd1, 16'h0000, 0, 0); step();
    chk("read_base_m1", bus.cpu_rdata, 16'h1357);
    drive(16'hFFFF, 16'h0000, 0, 0); step();
    chk("read_top", bus.cpu_rdata, 16'h0000);

    // TICK with PRESCALE=4
    drive(IO_BASE + 16'd4, 16'hFFFE, 1, 0); step();
    bus.cpu_we = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) chk("tick_k4", bus.cpu_rdata, 16'hFFFE);
      if (k == 5) chk("tick_ffff", bus.cpu_rdata, 16'hFFFF);
      if (k == 9) chk("tick_wrap0", bus.cpu_rdata, 16'h0000);
    end
    repeat (2) step();
    drive(IO_BASE + 16'd4, 16'h1111, 1, 0); step();   // lands on a wrap edge
    bus.cpu_we = 0;
    step();
    chk("tick_write_wins", bus.cpu_rdata, 16'h1111);
    repeat (3) step();
    step();
    chk("tick_after_load", bus.cpu_rdata, 16'h1112);

    // Back-to-back RAM / I/O / RAM
    drive(16'h0100, 16'h0000, 0, 0); step();
    chk("b2b_ram0", bus.cpu_rdata, 16'h00FF);
    drive(IO_BASE + 16'd1, 16'h0000, 0, 0); step();
    chk("b2b_io", bus.cpu_rdata, 16'h1234);
    drive(16'h0200, 16'h0000, 0, 0); step();
    chk("b2b_ram1", bus.cpu_rdata, 16'h0607);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r < 4)       a = IO_BASE + 16'($urandom_range(0, 4));
      else if (r == 4) a = IO_BASE + 16'($urandom_range(5, 16'hFFFF - IO_BASE));
      else if (r == 5) a = ($urandom_range(0, 1) == 0) ? IO_BASE - 16'd1 : 16'hFFFF;
      else             a = 16'($urandom_range(0, IO_BASE - 1));
      drive(a, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the CPU data port and one EXRAM port.
- Decodes an I/O window at the top of the address space into registered peripheral registers: synchronized switches, multi-digit 7-segment display with per-digit blanking, a sticky switch-change flag, and a prescaled tick counter.
- Addresses below the window pass through to RAM.
- I/O read data is returned with the same one-cycle latency as EXRAM.

Parameters:
- DATA_W, 16, CPU/RAM data width.
- ADDR_W, 16, address width.
- IO_BASE, 16'hCFFD, first address of the I/O window; window = IO_BASE..2^ADDR_W-1.
- NUM_DIGITS, 4, number of 7-seg digits; constraint 1..DATA_W/4.
- SW_W, 8, switch input width; constraint SW_W <= DATA_W.
- SYNC_STAGES, 2, switch synchronizer flops; constraint >= 2.
- PRESCALE, 50000, clk cycles per tick-counter increment; constraint >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_re  in  1  CPU read strobe; qualifies clear-on-read side effects only.
- cpu_rdata  out  DATA_W  read data, valid the cycle after the address.
- ram_addr  out  ADDR_W  address to EXRAM, equal to cpu_addr combinationally.
- ram_wdata  out  DATA_W  data to EXRAM, equal to cpu_wdata.
- ram_we  out  1  EXRAM write enable, equal to cpu_we & ~in_io.
- ram_q  in  DATA_W  EXRAM registered read data.
- switches  in  SW_W  asynchronous board switches.
- seg  out  NUM_DIGITS*7  active-low segments; digit i at bits [7i+6:7i]; bit0=a … bit6=g.
- sw_event  out  1  sticky switch-change flag, mirrors SW_EVENT bit0.

Behaviour:
- in_io = (cpu_addr >= IO_BASE). Register offset off = cpu_addr - IO_BASE.
- Register map:
  - off 0, SWITCHES (RO): zero-extended synchronized switches.
  - off 1, DISPLAY (RW): low NUM_DIGITS*4 bits; nibble i drives digit i; upper bits read 0.
  - off 2, BLANK (RW): low NUM_DIGITS bits; 1 = digit dark (all segments 1).
  - off 3, SW_EVENT (RO, clear-on-read): bit0.
  - off 4, TICK (RW): DATA_W-bit counter.
- Any other I/O offset: reads return 0; writes are dropped.
- I/O writes never reach RAM (ram_we=0 for the whole window). Writes to RO registers are ignored.
- Write timing: register writes take effect on the clk edge where cpu_we=1 and the address decodes. seg reflects the new DISPLAY/BLANK value one cycle later, because seg is registered from the decoder.
- Read path:
  - Edge N: capture io_sel_q <= in_io and io_rdata_q <= decoded register value.
  - Cycle N+1: cpu_rdata = io_sel_q ? io_rdata_q : ram_q. This matches EXRAM latency.
  - SWITCHES read returns the synchronized value sampled at edge N.
- Synchronizer: switches pass through SYNC_STAGES flops. sw_sync_prev holds the previous synchronized value.
- SW_EVENT:
  - Set when sw_sync != sw_sync_prev.
  - Cleared at edge N when cpu_re=1 and off=3; the read returns the pre-clear value.
  - Set and clear in the same cycle: set wins, flag stays 1.
- TICK:
  - Prescaler counts 0..PRESCALE-1. On wrap, TICK increments, wrapping 2^DATA_W-1 -> 0.
  - A CPU write to TICK loads cpu_wdata and resets the prescaler to 0; write wins over increment in the same cycle.
- Decoder: standard hex 0-F, active-low: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E (bit order g..a).
- Reset (async, any time including mid-transaction), all regs clear:
  - DISPLAY=0, BLANK=all ones (display dark), SW_EVENT=0, TICK=0, prescaler=0, synchronizer=0, io_sel_q=0, io_rdata_q=0.
  - Outputs: seg=all ones, sw_event=0, cpu_rdata=ram_q.
- Boundaries:
  - cpu_addr = IO_BASE-1 is RAM.
  - cpu_addr = all ones is unmapped I/O and reads 0.

Test Plan:
- Reset asserted mid-write to DISPLAY -> seg=all ones, sw_event=0. After release, read TICK at cycle 0 -> 0.
- Write 0x1234 to IO_BASE+1, then 0x0 to IO_BASE+2 -> next cycle seg digit0=7'h19 (4), digit3=7'h79 (1). Read IO_BASE+1 -> 0x1234 one cycle later.
- switches=8'hA5 held 3 cycles -> read IO_BASE returns 0x00A5, sw_event=1. Read IO_BASE+3 with cpu_re -> returns 1, sw_event=0 the next cycle. Change switches the same cycle as the clearing read -> flag stays 1.
- Write 0x00FF to RAM 0x0100 and 0xBEEF to IO_BASE+7 -> ram_we pulses only for 0x0100. Reading 0x0100 returns 0x00FF; reading IO_BASE+7 returns 0.
- PRESCALE=4: write 0xFFFE to TICK -> 0xFFFF after 4 cycles, 0x0000 after 8. A write landing on a wrap cycle loads the written value.
- Back-to-back reads RAM, I/O, RAM on consecutive cycles -> cpu_rdata alternates ram_q / io value / ram_q, each aligned one cycle after its address.
